// File: rtl/text_port_pkg.sv
// Shared constants and types for the CPU-port text display bridge.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package text_port_pkg;

  // CPU port map; 0x00-0x7F is the legacy direct-cell window.
  localparam logic [7:0] PORT_ROW   = 8'h80;
  localparam logic [7:0] PORT_ATTR  = 8'h84;
  localparam logic [7:0] PORT_COL   = 8'h85;
  localparam logic [7:0] PORT_DATA  = 8'h86;
  localparam logic [7:0] PORT_CLEAR = 8'h87;

  // Bit positions in the status byte read from PORT_ATTR.
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DROPPED = 1;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/text_clear_engine.sv
// Clear-screen engine: sweeps every display cell with {latched attr, CLEAR_CHAR}.
// Latency: one cell per cycle; the write for counter value k is offered one cycle ahead so the top can register it.
// Backpressure: none; a start while busy restarts the sweep at cell 0.
module text_clear_engine
  import text_port_pkg::*;
#(
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_attr,
  output logic              o_busy,
  output logic              o_wr_vld,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_data,
  output logic              o_done
);

  clr_state_e        r_state;
  clr_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [7:0]        r_attr;
  logic              w_last;

  // r_cnt is the cell currently on the display port while in CLEAR.
  assign w_last = (r_cnt == {ADDR_W{1'b1}});
  assign o_busy = (r_state == CLR_CLEAR);

  // State, counter and attribute snapshot taken at start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_attr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_start) begin
        r_attr <= i_attr;
      end
    end
  end

  // Next state plus the look-ahead write the top registers onto the display port.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_wr_vld    = 1'b0;
    o_done      = 1'b0;
    o_data      = {r_attr, CLEAR_CHAR};
    if (i_start) begin
      w_state_nxt = CLR_CLEAR;
      w_cnt_nxt   = '0;
      o_wr_vld    = 1'b1;
      o_data      = {i_attr, CLEAR_CHAR};
    end else if (r_state == CLR_CLEAR) begin
      if (w_last) begin
        w_state_nxt = CLR_IDLE;
        o_done      = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
        o_wr_vld  = 1'b1;
      end
    end
    o_addr = w_cnt_nxt;
  end

endmodule

// File: rtl/text_port_bridge.sv
// PicoBlaze port bus to text display bridge: cursor, attribute, status and optional clear engine (TEXT_PORT_BRIDGE_CLEAR_EN).
// Latency: display write one cycle after the CPU strobe; register reads are combinational from the port id.
// Backpressure: none toward the CPU; display writes issued during a clear are discarded and flagged in 'dropped'.
module text_port_bridge
  import text_port_pkg::*;
#(
  parameter int         COLS_LOG2  = 7,
  parameter int         ROWS_LOG2  = 5,
  parameter logic [7:0] RESET_ATTR = 8'h0F,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [7:0]                     i_cpu_port_id,
  input  logic                           i_cpu_write_strobe,
  input  logic                           i_cpu_read_strobe,
  input  logic [7:0]                     i_cpu_write_data,
  output logic [7:0]                     o_cpu_read_data,
  output logic                           o_cpu_read_sel,
  output logic                           o_dsp_en,
  output logic [ROWS_LOG2+COLS_LOG2-1:0] o_dsp_addr,
  output logic [15:0]                    o_dsp_data
);

  localparam int ADDR_W = ROWS_LOG2 + COLS_LOG2;

  logic [ROWS_LOG2-1:0] r_row;
  logic [COLS_LOG2-1:0] r_col;
  logic [7:0]           r_attr;
  logic                 r_dsp_en;
  logic [ADDR_W-1:0]    r_dsp_addr;
  logic [15:0]          r_dsp_data;

  logic w_wr_legacy, w_wr_row, w_wr_attr, w_wr_col, w_wr_data, w_wr_clear;
  logic w_cpu_disp, w_cpu_acc;
  logic [ADDR_W-1:0] w_cpu_addr;

  logic              w_busy, w_dropped, w_clr_vld, w_clr_done;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [15:0]       w_clr_data;

  assign w_wr_legacy = i_cpu_write_strobe & ~i_cpu_port_id[7];
  assign w_wr_row    = i_cpu_write_strobe & (i_cpu_port_id == PORT_ROW);
  assign w_wr_attr   = i_cpu_write_strobe & (i_cpu_port_id == PORT_ATTR);
  assign w_wr_col    = i_cpu_write_strobe & (i_cpu_port_id == PORT_COL);
  assign w_wr_data   = i_cpu_write_strobe & (i_cpu_port_id == PORT_DATA);
  assign w_wr_clear  = i_cpu_write_strobe & (i_cpu_port_id == PORT_CLEAR);

  // Legacy writes take the column from the port id; data-port writes use the cursor.
  assign w_cpu_disp = w_wr_legacy | w_wr_data;
  assign w_cpu_acc  = w_cpu_disp & ~w_busy;
  assign w_cpu_addr = w_wr_data ? {r_row, r_col} : {r_row, i_cpu_port_id[COLS_LOG2-1:0]};

`ifdef TEXT_PORT_BRIDGE_CLEAR_EN
  logic r_dropped;

  text_clear_engine #(
    .ADDR_W     (ADDR_W),
    .CLEAR_CHAR (CLEAR_CHAR)
  ) u_clear (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_wr_clear),
    .i_attr   (r_attr),
    .o_busy   (w_busy),
    .o_wr_vld (w_clr_vld),
    .o_addr   (w_clr_addr),
    .o_data   (w_clr_data),
    .o_done   (w_clr_done)
  );

  // Sticky flag for display writes lost to a clear; reading status acknowledges it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dropped <= 1'b0;
    end else if (w_cpu_disp && w_busy) begin
      r_dropped <= 1'b1;
    end else if (i_cpu_read_strobe && (i_cpu_port_id == PORT_ATTR)) begin
      r_dropped <= 1'b0;
    end
  end

  assign w_dropped = r_dropped;
`else
  logic w_unused_clr;

  assign w_unused_clr = w_wr_clear & i_cpu_read_strobe;
  assign w_busy       = 1'b0;
  assign w_dropped    = 1'b0;
  assign w_clr_vld    = 1'b0;
  assign w_clr_done   = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  // Cursor: a finished clear homes it; explicit row/col writes next; data-port writes advance it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_clr_done) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_wr_row) begin
      r_row <= i_cpu_write_data[ROWS_LOG2-1:0];
      r_col <= '0;
    end else if (w_wr_col) begin
      r_col <= i_cpu_write_data[COLS_LOG2-1:0];
    end else if (w_wr_data && !w_busy) begin
      r_col <= r_col + 1'b1;
      if (r_col == {COLS_LOG2{1'b1}}) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  // Attribute register; only affects writes issued after it changes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_attr <= RESET_ATTR;
    end else if (w_wr_attr) begin
      r_attr <= i_cpu_write_data;
    end
  end

  // Display port register: clear sweep wins; CPU writes land only outside a clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dsp_en   <= 1'b0;
      r_dsp_addr <= '0;
      r_dsp_data <= '0;
    end else begin
      r_dsp_en <= w_clr_vld | w_cpu_acc;
      if (w_clr_vld) begin
        r_dsp_addr <= w_clr_addr;
        r_dsp_data <= w_clr_data;
      end else if (w_cpu_acc) begin
        r_dsp_addr <= w_cpu_addr;
        r_dsp_data <= {r_attr, i_cpu_write_data};
      end
    end
  end

  assign o_dsp_en   = r_dsp_en;
  assign o_dsp_addr = r_dsp_addr;
  assign o_dsp_data = r_dsp_data;

  // Read mux over 0x84..0x87; everything else reads zero.
  always_comb begin
    o_cpu_read_data = 8'h00;
    o_cpu_read_sel  = (i_cpu_port_id[7:2] == PORT_ATTR[7:2]);
    case (i_cpu_port_id)
      PORT_ATTR: begin
        o_cpu_read_data[STAT_BUSY]    = w_busy;
        o_cpu_read_data[STAT_DROPPED] = w_dropped;
      end
      PORT_COL:   o_cpu_read_data[COLS_LOG2-1:0] = r_col;
      PORT_DATA:  o_cpu_read_data[ROWS_LOG2-1:0] = r_row;
      PORT_CLEAR: o_cpu_read_data = r_attr;
      default:    o_cpu_read_data = 8'h00;
    endcase
  end

endmodule
